// File: rtl/div_32bit_seq.sv
// Sequential 32-bit restoring divider for MIPS div/divu: one quotient bit per clock.
// Define DIV_SIGNED_EN to enable the two's-complement (div) path; otherwise all operations are unsigned.
module div_32bit_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] r_q, r_d;          // partial remainder
  logic [31:0] q_q, q_d;          // shifting dividend/quotient
  logic [31:0] d_q, d_d;          // divisor magnitude
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic        dbz_q, dbz_d;
  logic [32:0] r_shift;
  logic [31:0] a_mag, b_mag;

`ifdef DIV_SIGNED_EN
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;
  logic a_neg, b_neg;

  assign a_neg = is_signed & dividend[31];
  assign b_neg = is_signed & divisor[31];
  assign a_mag = a_neg ? (~dividend + 32'd1) : dividend;
  assign b_mag = b_neg ? (~divisor + 32'd1) : divisor;
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign a_mag = dividend;
  assign b_mag = divisor;
`endif

  // The 33rd remainder bit only lives for one cycle; the stored remainder is always < divisor.
  assign r_shift = {r_q, q_q[31]};

  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred on paths that skip it.
    state_d = state_q;
    count_d = count_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == 32'd0) begin
            quot_d  = 32'hFFFF_FFFF;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            q_d     = a_mag;
            d_d     = b_mag;
            r_d     = 32'd0;
            count_d = 5'd0;
`ifdef DIV_SIGNED_EN
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
`endif
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (r_shift >= {1'b0, d_q}) begin
          r_d = r_shift[31:0] - d_q;
          q_d = {q_q[30:0], 1'b1};
        end else begin
          r_d = r_shift[31:0];
          q_d = {q_q[30:0], 1'b0};
        end
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        // Results are published only here so the outputs never show partial values.
`ifdef DIV_SIGNED_EN
        quot_d = neg_quo_q ? (~q_q + 32'd1) : q_q;
        rem_d  = neg_rem_q ? (~r_q + 32'd1) : r_q;
`else
        quot_d = q_q;
        rem_d  = r_q;
`endif
        dbz_d   = 1'b0;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= 5'd0;
      r_q     <= 32'd0;
      q_q     <= 32'd0;
      d_q     <= 32'd0;
      quot_q  <= 32'd0;
      rem_q   <= 32'd0;
      dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
